// File: rtl/vga_plot_sink.sv
// rtl/vga_plot_sink.sv - 160x120x3 plot framebuffer with clear engine and 640x480@60 VGA scan-out.
// Optional feature macro: VGA_PLOT_SINK_DROP_COUNT_EN adds a saturating drop_count output.
module vga_plot_sink #(
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] plot_x,
  input  logic [6:0] plot_y,
  input  logic [2:0] plot_colour,
  input  logic       clear,
  output logic       plot_ready,
  output logic       dropped,
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
  output logic [7:0] drop_count,
`endif
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_clk
);

  localparam logic [9:0]  H_VIS     = 10'd640;
  localparam logic [9:0]  H_SYNC_S  = 10'd656;
  localparam logic [9:0]  H_SYNC_E  = 10'd751;
  localparam logic [9:0]  H_LAST    = 10'd799;
  localparam logic [9:0]  V_VIS     = 10'd480;
  localparam logic [9:0]  V_SYNC_S  = 10'd490;
  localparam logic [9:0]  V_SYNC_E  = 10'd491;
  localparam logic [9:0]  V_LAST    = 10'd524;
  localparam logic [7:0]  FB_W      = 8'd160;
  localparam logic [6:0]  FB_H      = 7'd120;
  localparam int          FB_SIZE   = 19200;
  localparam logic [14:0] CLR_LAST  = 15'd19199;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
  endfunction

  // ---------------- write side: clear engine and plot port ----------------
  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        dropped_q, dropped_d;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        plot_in_range;
  logic        plot_reject;

  logic [2:0]  fb_mem [0:FB_SIZE-1];

  assign plot_in_range = (plot_x < FB_W) && (plot_y < FB_H);
  assign plot_reject   = (state_q == ST_IDLE) && !clear && plot && !plot_in_range;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    dropped_d  = dropped_q;
    wr_en      = 1'b0;
    wr_addr    = clr_addr_q;
    wr_data    = BG_COLOUR;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (clr_addr_q == CLR_LAST) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      ST_IDLE: begin
        // A clear request wins over a plot presented in the same cycle.
        if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          dropped_d  = 1'b0;
        end else if (plot) begin
          if (plot_in_range) begin
            wr_en   = 1'b1;
            wr_addr = fb_addr(plot_y, plot_x);
            wr_data = plot_colour;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= wr_data;
    end
  end

  assign plot_ready = (state_q == ST_IDLE);
  assign dropped    = dropped_q;

`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == ST_IDLE) && clear) begin
      drop_cnt_d = '0;
    end else if (plot_reject && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_reject;
  assign unused_reject = plot_reject;
`endif

  // ---------------- read side: timing, address, memory, output ----------------
  logic       pe_q, pe_d;
  logic       vga_clk_q, vga_clk_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  always_comb begin
    pe_d      = ~pe_q;
    vga_clk_d = pe_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (pe_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pe_q      <= 1'b0;
      vga_clk_q <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
    end else begin
      pe_q      <= pe_d;
      vga_clk_q <= vga_clk_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
    end
  end

  // Stage 1: address plus raw sync/visible flags for the current counter value.
  logic        vis_raw, hs_raw, vs_raw;
  logic [14:0] addr_q, addr_d;
  logic        vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;

  assign vis_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_raw  = !((hc_q >= H_SYNC_S) && (hc_q <= H_SYNC_E));
  assign vs_raw  = !((vc_q >= V_SYNC_S) && (vc_q <= V_SYNC_E));

  // Stage 2 travels with the memory read; stage 3 is the output register.
  logic [2:0] rd_q;
  logic       vis2_q, vis2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [2:0] rgb_q, rgb_d;
  logic       blank3_q, blank3_d, hs3_q, hs3_d, vs3_q, vs3_d;

  always_comb begin
    addr_d   = addr_q;
    vis1_d   = vis1_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    vis2_d   = vis2_q;
    hs2_d    = hs2_q;
    vs2_d    = vs2_q;
    rgb_d    = rgb_q;
    blank3_d = blank3_q;
    hs3_d    = hs3_q;
    vs3_d    = vs3_q;
    if (pe_q) begin
      addr_d   = vis_raw ? fb_addr(vc_q[8:2], hc_q[9:2]) : 15'd0;
      vis1_d   = vis_raw;
      hs1_d    = hs_raw;
      vs1_d    = vs_raw;
      vis2_d   = vis1_q;
      hs2_d    = hs1_q;
      vs2_d    = vs1_q;
      rgb_d    = vis2_q ? rd_q : 3'b000;
      blank3_d = vis2_q;
      hs3_d    = hs2_q;
      vs3_d    = vs2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      vis1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      vis2_q   <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      rgb_q    <= '0;
      blank3_q <= 1'b0;
      hs3_q    <= 1'b1;
      vs3_q    <= 1'b1;
    end else begin
      addr_q   <= addr_d;
      vis1_q   <= vis1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      vis2_q   <= vis2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb_q    <= rgb_d;
      blank3_q <= blank3_d;
      hs3_q    <= hs3_d;
      vs3_q    <= vs3_d;
    end
  end

  // Read port kept reset-free so it maps onto a block RAM output register.
  always_ff @(posedge clk) begin
    if (pe_q) begin
      rd_q <= fb_mem[addr_q];
    end
  end

  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};
  assign vga_hs      = hs3_q;
  assign vga_vs      = vs3_q;
  assign vga_blank_n = blank3_q;
  assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb/tb_vga_plot_sink.sv - directed table-driven bench for vga_plot_sink.
module tb_vga_plot_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       clear;
  logic       plot_ready;
  logic       dropped;
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_clk;

  always #10 clk = ~clk;

  vga_plot_sink #(.BG_COLOUR(3'b001), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .clear(clear), .plot_ready(plot_ready), .dropped(dropped),
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
  );

  // clk edges since reset was last released
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         hc;
    int         vc;
    logic [2:0] rgb;
    logic       blank_n;
    logic       hs;
  } px_t;

  function automatic px_t mk(input int hc, input int vc, input logic [2:0] rgb,
                             input logic blank_n, input logic hs);
    px_t p;
    p.hc = hc; p.vc = vc; p.rgb = rgb; p.blank_n = blank_n; p.hs = hs;
    return p;
  endfunction

  // Output for counter (hc,vc) is held right after edge 2*(vc*800+hc)+6.
  task automatic check_px(input px_t p, input string tag);
    int t;
    logic [31:0] exp;
    t = 2 * (p.vc * 800 + p.hc) + 6;
    exp = {5'b0, {8{p.rgb[2]}}, {8{p.rgb[1]}}, {8{p.rgb[0]}}, p.hs, 1'b1, p.blank_n};
    if (cyc > t) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s px(%0d,%0d): bench late, cyc %0d expected <= %0d", tag, p.hc, p.vc, cyc, t);
    end else begin
      while (cyc < t) @(negedge clk);
      check($sformatf("%s px(%0d,%0d)", tag, p.hc, p.vc),
            {5'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " outputs"},
          {2'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, plot_ready, dropped},
          {2'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
    check({tag, " drop_count"}, drop_count, 0);
`endif
  endtask

  px_t tab1[$];
  px_t tab2[$];

  initial begin
    int hi;

    tab1.push_back(mk(0,   13, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(639, 13, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(640, 13, 3'b000, 1'b0, 1'b1));
    tab1.push_back(mk(655, 13, 3'b000, 1'b0, 1'b1));
    tab1.push_back(mk(656, 13, 3'b000, 1'b0, 1'b0));
    tab1.push_back(mk(751, 13, 3'b000, 1'b0, 1'b0));
    tab1.push_back(mk(752, 13, 3'b000, 1'b0, 1'b1));
    tab1.push_back(mk(799, 13, 3'b000, 1'b0, 1'b1));
    tab1.push_back(mk(39,  20, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(40,  20, 3'b100, 1'b1, 1'b1));
    tab1.push_back(mk(43,  20, 3'b100, 1'b1, 1'b1));
    tab1.push_back(mk(44,  20, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(39,  23, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(43,  23, 3'b100, 1'b1, 1'b1));
    tab1.push_back(mk(0,   24, 3'b111, 1'b1, 1'b1));
    tab1.push_back(mk(40,  24, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(3,   27, 3'b111, 1'b1, 1'b1));
    tab1.push_back(mk(4,   27, 3'b001, 1'b1, 1'b1));
    tab1.push_back(mk(0,   28, 3'b001, 1'b1, 1'b1));

    tab2.push_back(mk(11,  4, 3'b001, 1'b1, 1'b1));
    tab2.push_back(mk(12,  4, 3'b001, 1'b1, 1'b1));
    tab2.push_back(mk(640, 4, 3'b000, 1'b0, 1'b1));
    tab2.push_back(mk(13,  5, 3'b001, 1'b1, 1'b1));
    tab2.push_back(mk(700, 5, 3'b000, 1'b0, 1'b0));

    reset = 1'b1; plot = 1'b0; clear = 1'b0;
    plot_x = '0; plot_y = '0; plot_colour = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset0");
    reset = 1'b0;

    while (!plot_ready && cyc < 25000) @(negedge clk);
    check("clear_len_after_reset", cyc, 19200);

    plot = 1'b1;
    plot_x = 8'd10;  plot_y = 7'd5;   plot_colour = 3'b100; @(negedge clk);
    plot_x = 8'd0;   plot_y = 7'd6;   plot_colour = 3'b111; @(negedge clk);
    plot_x = 8'd160; plot_y = 7'd6;   plot_colour = 3'b010; @(negedge clk);
    plot_x = 8'd0;   plot_y = 7'd120; plot_colour = 3'b010; @(negedge clk);
    plot = 1'b0;
    check("dropped_after_bad", dropped, 1);
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
    check("drop_count_2", drop_count, 2);
`endif

    for (int i = 0; i < tab1.size(); i++) check_px(tab1[i], "frame1");

    plot = 1'b1; plot_x = 8'd255; plot_y = 7'd0;
    repeat (300) @(negedge clk);
    plot = 1'b0;
    check("dropped_after_300", dropped, 1);
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
    check("drop_count_sat", drop_count, 255);
`endif

    clear = 1'b1; plot = 1'b1; plot_x = 8'd2; plot_y = 7'd8; plot_colour = 3'b100;
    @(negedge clk);
    clear = 1'b0; plot = 1'b0;
    check("ready_low_on_clear", plot_ready, 0);
    check("dropped_cleared", dropped, 0);
`ifdef VGA_PLOT_SINK_DROP_COUNT_EN
    check("drop_count_cleared", drop_count, 0);
`endif

    hi = 0;
    for (int i = 0; i < 9000; i++) begin
      plot = (i < 20);
      plot_x = 8'd200;
      @(negedge clk);
      if (plot_ready) hi++;
    end
    plot = 1'b0;
    check("ready_high_during_clear", hi, 0);
    check("dropped_during_clear", dropped, 0);

    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_clear");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("vga_clk_phase%0d", k), vga_clk, (k % 2 == 0));
    end
    check_px(mk(0, 0, 3'b001, 1'b1, 1'b1), "restart");

    while (cyc < 500) @(negedge clk);
    plot = 1'b1; plot_x = 8'd3; plot_y = 7'd1; plot_colour = 3'b100;
    @(negedge clk);
    clear = 1'b1; plot_x = 8'd160; plot_y = 7'd0;
    @(negedge clk);
    clear = 1'b0; plot = 1'b0;
    check("dropped_after_clear_plots", dropped, 0);

    for (int i = 0; i < tab2.size(); i++) check_px(tab2[i], "restart");

    while (!plot_ready && cyc < 25000) @(negedge clk);
    check("clear_len_after_mid_reset", cyc, 19200);
    check("dropped_end", dropped, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
